modulo_updown_counter: RTL and testbench

Parametrised up/down counter with programmable modulo limit, synchronous load, wrap or saturate mode and a terminal-count pulse. It is the successor to the fixed 8-bit programmable counter in the user design. It counts rising edges of an external, asynchronous count pulse and sits between the `ui_in` control pins and the `uo_out` display pins.

---
 rtl/modulo_updown_counter.sv | 96 +++++++++
 tb/tb_modulo_updown_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_updown_counter.sv
// Up/down counter over 0..limit with load, wrap/saturate and a terminal-count pulse.
// Define MODULO_COUNTER_SYNC_EN to pass cnt_in through a SYNC_STAGES-deep synchroniser.
module modulo_updown_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cnt_in,
  input  logic             load,
  input  logic             up_down,
  input  logic             sat,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic             cnt_cond;
  logic             prev_q;
  logic             ev;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

`ifdef MODULO_COUNTER_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cnt_in};
    end
  end

  assign cnt_cond = sync_q[SYNC_STAGES-1];
`else
  // Synchroniser depth is irrelevant when cnt_in is already synchronous.
  logic unused_sync_stages;
  assign unused_sync_stages = ^SYNC_STAGES;
  assign cnt_cond           = cnt_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= cnt_cond;
    end
  end

  assign ev = enable & cnt_cond & ~prev_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      // A coincident event is dropped, not deferred.
      count_d = (load_val > limit) ? limit : load_val;
    end else if (ev) begin
      if (up_down) begin
        if (count_q < limit) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = sat ? limit : '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q > limit) begin
          // Limit was lowered underneath us: pull back into range silently.
          count_d = limit;
        end else if (count_q == '0) begin
          count_d = sat ? '0 : limit;
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench for modulo_updown_counter: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them.
module tb_modulo_updown_counter;

`ifdef MODULO_COUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       cnt_in;
  logic       load;
  logic       up_down;
  logic       sat;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [7:0] count;
  logic       tc;

  modulo_updown_counter #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .cnt_in  (cnt_in),
    .load    (load),
    .up_down (up_down),
    .sat     (sat),
    .load_val(load_val),
    .limit   (limit),
    .count   (count),
    .tc      (tc)
  );

  typedef struct {
    int         at;
    logic [7:0] c;
    logic       t;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   tests;
  int   fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.at < cyc) begin
        fails++;
        $display("FAIL %s: check slot %0d missed at cycle %0d", e.name, e.at, cyc);
      end else if (count !== e.c || tc !== e.t) begin
        fails++;
        $display("FAIL %s: count=%0d tc=%0b, expected count=%0d tc=%0b",
                 e.name, count, tc, e.c, e.t);
      end
    end
  end

  function automatic void push(input int at, input logic [7:0] c, input logic t,
                               input string name);
    exp_t e;
    e.at   = at;
    e.c    = c;
    e.t    = t;
    e.name = name;
    q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cnt_in pulse: count must be unchanged one edge before the update, updated on it,
  // and tc must drop again afterwards.
  task automatic pulse(input logic [7:0] prev, input logic [7:0] exp_c, input logic exp_tc,
                       input string name);
    cnt_in = 1'b1;
    push(cyc + LAT, prev, 1'b0, {name, "_pre"});
    push(cyc + 1 + LAT, exp_c, exp_tc, name);
    push(cyc + 2 + LAT, exp_c, 1'b0, {name, "_hold"});
    repeat (LAT + 2) step();
    cnt_in = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic do_load(input logic [7:0] val, input logic [7:0] lim, input logic [7:0] exp_c,
                         input string name);
    limit    = lim;
    load_val = val;
    load     = 1'b1;
    push(cyc + 1, exp_c, 1'b0, name);
    step();
    load = 1'b0;
    step();
  endtask

  logic [7:0] up_exp  [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
  logic [7:0] up_prev [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    cnt_in   = 1'b0;
    load     = 1'b0;
    up_down  = 1'b1;
    sat      = 1'b0;
    load_val = 8'd0;
    limit    = 8'd5;
    repeat (3) step();
    push(cyc + 1, 8'd0, 1'b0, "reset");
    step();
    rst_n  = 1'b1;
    enable = 1'b1;
    step();

    // Wrap, up, limit 5
    for (int i = 0; i < 7; i++) begin
      pulse(up_prev[i], up_exp[i], (i == 5), $sformatf("up_wrap%0d", i));
    end

    // Down, saturate from 1
    do_load(8'd1, 8'd5, 8'd1, "load1");
    sat     = 1'b1;
    up_down = 1'b0;
    pulse(8'd1, 8'd0, 1'b0, "sat_down0");
    pulse(8'd0, 8'd0, 1'b1, "sat_down1");
    pulse(8'd0, 8'd0, 1'b1, "sat_down2");

    // Load above limit with coincident conditioned edge
    cnt_in = 1'b1;
    repeat (LAT) step();
    load_val = 8'd9;
    limit    = 8'd5;
    load     = 1'b1;
    push(cyc + 1, 8'd5, 1'b0, "load_clamp");
    step();
    load = 1'b0;
    push(cyc + 2, 8'd5, 1'b0, "load_drop");
    repeat (LAT + 3) step();
    cnt_in = 1'b0;
    repeat (LAT + 2) step();

    // Limit lowered at run time
    sat = 1'b0;
    do_load(8'd50, 8'd200, 8'd50, "load50a");
    limit   = 8'd10;
    up_down = 1'b0;
    pulse(8'd50, 8'd10, 1'b0, "lower_down");
    do_load(8'd50, 8'd200, 8'd50, "load50b");
    limit   = 8'd10;
    up_down = 1'b1;
    pulse(8'd50, 8'd0, 1'b1, "lower_up");

    // Disabled: no change
    enable = 1'b0;
    pulse(8'd0, 8'd0, 1'b0, "disabled");
    enable = 1'b1;

    // Latency and plain step
    do_load(8'd3, 8'd5, 8'd3, "load3");
    pulse(8'd3, 8'd4, 1'b0, "latency");

    // Down wrap at 0
    do_load(8'd0, 8'd5, 8'd0, "load0");
    up_down = 1'b0;
    pulse(8'd0, 8'd5, 1'b1, "wrap_down");

    // limit = 0
    do_load(8'd0, 8'd0, 8'd0, "load_lim0");
    up_down = 1'b1;
    pulse(8'd0, 8'd0, 1'b1, "lim0_up");
    up_down = 1'b0;
    pulse(8'd0, 8'd0, 1'b1, "lim0_down");

    // Full-range natural wrap
    do_load(8'd255, 8'd255, 8'd255, "load255");
    up_down = 1'b1;
    pulse(8'd255, 8'd0, 1'b1, "full_wrap");

    // Reset overrides a simultaneous load
    do_load(8'd3, 8'd5, 8'd3, "load3b");
    load_val = 8'd4;
    load     = 1'b1;
    rst_n    = 1'b0;
    push(cyc + 1, 8'd0, 1'b0, "mid_reset");
    step();
    rst_n = 1'b1;
    load  = 1'b0;
    step();

    for (int i = 0; i < 50 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
